// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and the link timing constants
// used by the receiver, the transmitter and the baud divider.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 666;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high and idle-low lines both come out of reset quiet.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rxd on clk, recovers frames at mid-bit and
// hands each byte over through a one-deep hold register with valid/ack.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 rxd_d;
    logic [1:0]           fill;
    logic                 seen_high;
    logic                 fall;
    logic                 cnt_zero;
    uart_rx_state_t       state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 good_pend;
    logic                 err_pend;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Edge detector; seen_high ignores the synchronizer's reset value so that a
    // line caught low mid-frame at reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_d     <= 1'b1;
            fill      <= 2'b00;
            seen_high <= 1'b0;
        end else begin
            rxd_d <= rxd_s;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && rxd_s) begin
                seen_high <= 1'b1;
            end
        end
    end

    assign fall     = rxd_d & ~rxd_s & seen_high;
    assign cnt_zero = (cnt == '0);

    // Frame FSM; the counter is reloaded at every sample point and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            good_pend <= 1'b0;
            err_pend  <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            good_pend <= 1'b0;
            err_pend  <= 1'b0;
            if (!cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt     <= HALF_LOAD;
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        if (!rxd_s) begin
                            cnt   <= BIT_LOAD;
                            idx   <= '0;
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        shift[idx] <= rxd_s;
                        cnt        <= BIT_LOAD;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (cnt_zero) begin
                        if (rxd_s) begin
                            good_pend <= 1'b1;
                            state     <= IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Hold register: an ack on the load edge frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= err_pend;
            if (good_pend) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// checked every cycle against an event-timeline model of the receiver.
module tb_uart_rx;

    localparam int CPB  = 25;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Model: expected events keyed by the edge they become visible on (1=byte, 2=frame error),
    // plus windows of edges after which rx_busy must read 1.
    int         ev_kind[int];
    logic [7:0] ev_data[int];
    int         b_lo[$];
    int         b_hi[$];
    bit         ack_at[int];
    bit         rand_ack = 1'b0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       e_ovr, e_ferr, e_busy;

    int n_rise = 0;
    int n_ovr = 0;
    int n_ferr = 0;
    int last_rise = -1;
    logic prev_valid = 1'b0;

    // Reference model and per-cycle compare
    always @(posedge clk) begin
        cyc++;
        e_ovr  = 1'b0;
        e_ferr = 1'b0;
        e_busy = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else begin
            if (ev_kind.exists(cyc) && ev_kind[cyc] == 1) begin
                if (!m_valid || rx_ack) begin
                    m_data  = ev_data[cyc];
                    m_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else begin
                if (ev_kind.exists(cyc)) e_ferr = 1'b1;
                if (rx_ack) m_valid = 1'b0;
            end
            foreach (b_lo[i]) begin
                if (b_lo[i] <= cyc && cyc <= b_hi[i]) e_busy = 1'b1;
            end
        end
        #2;
        n_cmp++;
        if ({rx_valid, rx_data, rx_overrun, rx_frame_err, rx_busy} !==
            {m_valid, m_data, e_ovr, e_ferr, e_busy}) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got valid=%b data=%h ovr=%b ferr=%b busy=%b, want valid=%b data=%h ovr=%b ferr=%b busy=%b",
                     cyc, rx_valid, rx_data, rx_overrun, rx_frame_err, rx_busy,
                     m_valid, m_data, e_ovr, e_ferr, e_busy);
        end
        if (rx_valid && !prev_valid) begin
            n_rise++;
            last_rise = cyc;
        end
        prev_valid = rx_valid;
        if (rx_overrun) n_ovr++;
        if (rx_frame_err) n_ferr++;
    end

    // Ack driver: either scheduled edges or random
    always @(posedge clk) begin
        #1;
        rx_ack = rand_ack ? ($urandom_range(0, 5) == 0) : ack_at.exists(cyc + 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, got, exp);
        end
    endtask

    // Sends one frame with bit length len; stop_low>0 holds the stop bit low that long.
    task automatic send_frame(input logic [7:0] b, input int len, input int stop_low);
        int k, t0, ts;
        k  = cyc;
        t0 = k + 3;
        ts = t0 + HALF + 9 * CPB;
        b_lo.push_back(t0);
        if (stop_low == 0) begin
            b_hi.push_back(ts - 1);
            ev_kind[ts + 1] = 1;
            ev_data[ts + 1] = b;
        end else begin
            b_hi.push_back(k + 9 * len + stop_low + 2);
            ev_kind[ts + 1] = 2;
            ev_data[ts + 1] = 8'h00;
        end
        drive_bit(1'b0, len);
        for (int i = 0; i < 8; i++) drive_bit(b[i], len);
        if (stop_low == 0) drive_bit(1'b1, len);
        else drive_bit(1'b0, stop_low);
        rxd = 1'b1;
    endtask

    initial begin
        int k, r0, o0, f0, R;
        logic [7:0] fb;
        repeat (3) tick();
        rst = 1'b0;
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_busy", rx_busy, 0);
        idle(20);

        // 0xA5 at exact rate: valid visible 3 (sync+edge) + 12 + 9*25 + 1 = 241 edges after the pin fall
        k = cyc;
        send_frame(8'hA5, CPB, 0);
        idle(10);
        check("A5 valid rise cycle", last_rise, k + 241);
        check("A5 data", rx_data, 8'hA5);
        check("A5 no error pulses", n_ovr + n_ferr, 0);

        // Back-to-back 0x3C, 0xC3 with ack after each
        ack_at[cyc + 2] = 1'b1;
        idle(5);
        r0 = n_rise;
        o0 = n_ovr;
        k = cyc;
        ack_at[k + 244] = 1'b1;
        send_frame(8'h3C, CPB, 0);
        ack_at[cyc + 244] = 1'b1;
        send_frame(8'hC3, CPB, 0);
        idle(10);
        check("b2b valid events", n_rise - r0, 2);
        check("b2b last data", rx_data, 8'hC3);
        check("b2b no overrun", n_ovr - o0, 0);

        // 0x11 then 0x22 with no ack: overrun, old byte kept
        send_frame(8'h11, CPB, 0);
        idle(3);
        send_frame(8'h22, CPB, 0);
        idle(5);
        check("overrun data kept", rx_data, 8'h11);
        check("overrun valid", rx_valid, 1);
        check("overrun pulses", n_ovr - o0, 1);

        // Repeat with ack on the exact load edge
        ack_at[cyc + 2] = 1'b1;
        idle(5);
        o0 = n_ovr;
        send_frame(8'h11, CPB, 0);
        idle(3);
        k = cyc;
        ack_at[k + 241] = 1'b1;
        send_frame(8'h22, CPB, 0);
        idle(5);
        check("ack-on-load data", rx_data, 8'h22);
        check("ack-on-load valid", rx_valid, 1);
        check("ack-on-load no overrun", n_ovr - o0, 0);

        // Short glitch is a false start, then 0x00
        ack_at[cyc + 2] = 1'b1;
        idle(5);
        r0 = n_rise;
        k = cyc;
        b_lo.push_back(k + 3);
        b_hi.push_back(k + 3 + HALF - 1);
        drive_bit(1'b0, 5);
        idle(40);
        check("glitch no valid", n_rise - r0, 0);
        send_frame(8'h00, CPB, 0);
        idle(10);
        check("00 after glitch", rx_data, 8'h00);
        check("00 valid event", n_rise - r0, 1);

        // 0x55 with stop held low for 20 bit times
        ack_at[cyc + 2] = 1'b1;
        idle(5);
        f0 = n_ferr;
        r0 = n_rise;
        send_frame(8'h55, CPB, 20 * CPB);
        check("break busy held", rx_busy, 1);
        idle(10);
        check("break frame err pulses", n_ferr - f0, 1);
        check("break valid stays 0", n_rise - r0 + rx_valid, 0);
        check("break busy released", rx_busy, 0);
        send_frame(8'h7E, CPB, 0);
        idle(10);
        check("7E after break", rx_data, 8'h7E);

        // Reset during data bit 4 of 0xE5 (line low at reset, only highs after)
        r0 = n_rise;
        fb = 8'hE5;
        k = cyc;
        b_lo.push_back(k + 3);
        b_hi.push_back(k + 100000);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(fb[i], CPB);
        drive_bit(fb[4], HALF);
        rst = 1'b1;
        R = cyc + 1;
        b_hi[b_hi.size() - 1] = R - 1;
        tick();
        check("midreset valid", rx_valid, 0);
        check("midreset data", rx_data, 0);
        check("midreset busy", rx_busy, 0);
        tick();
        rst = 1'b0;
        drive_bit(fb[4], CPB - HALF - 2);
        for (int i = 5; i < 8; i++) drive_bit(fb[i], CPB);
        idle(40);
        check("midreset no valid", n_rise - r0, 0);
        send_frame(8'h81, CPB, 0);
        idle(10);
        check("81 after reset", rx_data, 8'h81);

        // Randomized frames, bit length jitter, occasional breaks, random acks
        rand_ack = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int len, sl;
            b   = 8'($urandom);
            len = $urandom_range(CPB - 1, CPB + 1);
            sl  = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 60) : 0;
            send_frame(b, len, sl);
            if (sl != 0) idle($urandom_range(3, 20));
            else idle($urandom_range(0, 20));
        end
        rand_ack = 1'b0;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
